// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer for the single-bus DataPath (IDLE, T0..T6, FAULT).
// Optional instruction counter output instr_count is enabled by defining SEQ_INSTR_COUNT_EN.
module control_sequencer (
  input  logic        w_clock,
  input  logic        w_clear,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic        s_PC,
  output logic        s_Zlow,
  output logic        s_Zhigh,
  output logic        s_MDR,
  output logic        e_MAR,
  output logic        e_PC,
  output logic        e_MDR,
  output logic        e_IR,
  output logic        e_Y,
  output logic        e_Z,
  output logic        e_HI,
  output logic        e_LO,
  output logic        w_IncPC,
  output logic        w_read,
  output logic        e_alu,
  output logic [4:0]  opcode,
  output logic [15:0] reg_out,
  output logic [15:0] reg_in,
  output logic        done,
  output logic        fault
`ifdef SEQ_INSTR_COUNT_EN
  ,
  output logic [15:0] instr_count
`endif
);

  typedef enum logic [3:0] {
    IDLE,
    T0,
    T1,
    T2,
    T3,
    T4,
    T5,
    T6,
    FAULT
  } state_t;

  localparam logic [4:0] OP_NOT  = 5'd4;
  localparam logic [4:0] OP_MUL  = 5'd5;
  localparam logic [4:0] OP_DIV  = 5'd6;
  localparam logic [4:0] OP_NEG  = 5'd12;
  localparam logic [4:0] OP_LAST = 5'd12;

  state_t     state;
  logic       t1_wait;
  logic [4:0] op;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic       legal;
  logic       wide;
  logic       unary;
  logic       unused_ir;

  assign op        = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign legal     = (op <= OP_LAST);
  assign wide      = (op == OP_MUL) || (op == OP_DIV);
  assign unary     = (op == OP_NOT) || (op == OP_NEG);
  assign unused_ir = ^ir[14:0];

  // opcode is latched on the way into T4 so it holds between ALU steps;
  // it is cleared whenever the sequencer parks in IDLE or FAULT.
  always_ff @(posedge w_clock) begin
    if (w_clear) begin
      state   <= IDLE;
      t1_wait <= 1'b0;
      opcode  <= '0;
    end else begin
      case (state)
        IDLE: if (run) state <= T0;
        T0: begin
          state   <= T1;
          t1_wait <= 1'b0;
        end
        T1: begin
          if (mem_ready) state <= T2;
          else           t1_wait <= 1'b1;
        end
        T2: state <= T3;
        T3: begin
          if (legal) begin
            state  <= T4;
            opcode <= op;
          end else begin
            state  <= FAULT;
            opcode <= '0;
          end
        end
        T4: state <= T5;
        T5: begin
          if (wide) begin
            state <= T6;
          end else if (run) begin
            state <= T0;
          end else begin
            state  <= IDLE;
            opcode <= '0;
          end
        end
        T6: begin
          if (run) begin
            state <= T0;
          end else begin
            state  <= IDLE;
            opcode <= '0;
          end
        end
        FAULT: state <= FAULT;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_PC    = 1'b0;
    s_Zlow  = 1'b0;
    s_Zhigh = 1'b0;
    s_MDR   = 1'b0;
    e_MAR   = 1'b0;
    e_PC    = 1'b0;
    e_MDR   = 1'b0;
    e_IR    = 1'b0;
    e_Y     = 1'b0;
    e_Z     = 1'b0;
    e_HI    = 1'b0;
    e_LO    = 1'b0;
    w_IncPC = 1'b0;
    w_read  = 1'b0;
    e_alu   = 1'b0;
    reg_out = '0;
    reg_in  = '0;
    done    = 1'b0;
    fault   = 1'b0;
    case (state)
      T0: begin
        s_PC    = 1'b1;
        e_MAR   = 1'b1;
        w_IncPC = 1'b1;
        e_Z     = 1'b1;
      end
      T1: begin
        s_Zlow = 1'b1;
        e_PC   = !t1_wait;
        w_read = 1'b1;
        e_MDR  = 1'b1;
      end
      T2: begin
        s_MDR = 1'b1;
        e_IR  = 1'b1;
      end
      T3: begin
        if (legal) begin
          reg_out = 16'd1 << rb;
          e_Y     = 1'b1;
        end
      end
      T4: begin
        reg_out = unary ? (16'd1 << rb) : (16'd1 << rc);
        e_alu   = 1'b1;
        e_Z     = 1'b1;
      end
      T5: begin
        s_Zlow = 1'b1;
        if (wide) begin
          e_LO = 1'b1;
        end else begin
          reg_in = 16'd1 << ra;
          done   = 1'b1;
        end
      end
      T6: begin
        s_Zhigh = 1'b1;
        e_HI    = 1'b1;
        done    = 1'b1;
      end
      FAULT: fault = 1'b1;
      default: ;
    endcase
  end

`ifdef SEQ_INSTR_COUNT_EN
  always_ff @(posedge w_clock) begin
    if (w_clear)   instr_count <= '0;
    else if (done) instr_count <= instr_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Cycle-exact scoreboard bench for control_sequencer: each stimulus cycle queues the
// expected output vector, which a negedge monitor pops and compares.
module tb_control_sequencer;

  logic        w_clock;
  logic        w_clear;
  logic        run;
  logic        mem_ready;
  logic [31:0] ir;
  logic        s_PC, s_Zlow, s_Zhigh, s_MDR;
  logic        e_MAR, e_PC, e_MDR, e_IR, e_Y, e_Z, e_HI, e_LO;
  logic        w_IncPC, w_read, e_alu;
  logic [4:0]  opcode;
  logic [15:0] reg_out, reg_in;
  logic        done, fault;
`ifdef SEQ_INSTR_COUNT_EN
  logic [15:0] instr_count;
`endif

  control_sequencer dut (
    .w_clock(w_clock), .w_clear(w_clear), .run(run), .mem_ready(mem_ready), .ir(ir),
    .s_PC(s_PC), .s_Zlow(s_Zlow), .s_Zhigh(s_Zhigh), .s_MDR(s_MDR),
    .e_MAR(e_MAR), .e_PC(e_PC), .e_MDR(e_MDR), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z),
    .e_HI(e_HI), .e_LO(e_LO), .w_IncPC(w_IncPC), .w_read(w_read), .e_alu(e_alu),
    .opcode(opcode), .reg_out(reg_out), .reg_in(reg_in), .done(done), .fault(fault)
`ifdef SEQ_INSTR_COUNT_EN
    , .instr_count(instr_count)
`endif
  );

  localparam logic [16:0] C_SPC  = 17'h10000;
  localparam logic [16:0] C_SZL  = 17'h08000;
  localparam logic [16:0] C_SZH  = 17'h04000;
  localparam logic [16:0] C_SMDR = 17'h02000;
  localparam logic [16:0] C_EMAR = 17'h01000;
  localparam logic [16:0] C_EPC  = 17'h00800;
  localparam logic [16:0] C_EMDR = 17'h00400;
  localparam logic [16:0] C_EIR  = 17'h00200;
  localparam logic [16:0] C_EY   = 17'h00100;
  localparam logic [16:0] C_EZ   = 17'h00080;
  localparam logic [16:0] C_EHI  = 17'h00040;
  localparam logic [16:0] C_ELO  = 17'h00020;
  localparam logic [16:0] C_INC  = 17'h00010;
  localparam logic [16:0] C_RD   = 17'h00008;
  localparam logic [16:0] C_ALU  = 17'h00004;
  localparam logic [16:0] C_DONE = 17'h00002;
  localparam logic [16:0] C_FLT  = 17'h00001;

  logic [53:0] obs;
  assign obs = {s_PC, s_Zlow, s_Zhigh, s_MDR, e_MAR, e_PC, e_MDR, e_IR, e_Y, e_Z, e_HI, e_LO,
                w_IncPC, w_read, e_alu, done, fault, opcode, reg_out, reg_in};

  string       tags[$];
  logic [53:0] exps[$];
  int          latq[$];
  int          cntq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          t0_cyc = 0;
  logic [4:0]  prev_op = '0;
  int          exp_count = 0;

  initial w_clock = 1'b0;
  always #5 w_clock = ~w_clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [53:0] ov(input logic [16:0] c, input logic [4:0] o,
                                     input logic [15:0] ro, input logic [15:0] ri);
    return {c, o, ro, ri};
  endfunction

  // Monitor: one queued expectation per cycle, plus done-triggered latency/counter checks.
  always @(negedge w_clock) begin
    cyc++;
    if (exps.size() != 0) checkOutput(tags.pop_front(), {10'b0, obs}, {10'b0, exps.pop_front()});
    if (s_PC === 1'b1) t0_cyc = cyc;
    if (done === 1'b1) begin
      if (latq.size() != 0) checkOutput("latency", 64'(cyc - t0_cyc + 1), 64'(latq.pop_front()));
      else                  checkOutput("latency_extra_done", 64'(cyc - t0_cyc + 1), 64'd0);
`ifdef SEQ_INSTR_COUNT_EN
      if (cntq.size() != 0) checkOutput("instr_count", {48'b0, instr_count}, 64'(cntq.pop_front()));
`endif
    end
  end

  task automatic tick(input string tag, input logic [53:0] exp);
    tags.push_back(tag);
    exps.push_back(exp);
    @(posedge w_clock);
    #1;
  endtask

  // Runs one instruction starting in a T0 cycle; inputs set before each tick act on the closing edge.
  task automatic applyStimulus(input string nm, input logic [31:0] iv, input int wait_n,
                               input logic run_after, input logic abort_t4);
    logic [4:0]  op;
    logic [3:0]  ra, rb, rc;
    logic [15:0] ro4;
    op = iv[31:27];
    ra = iv[26:23];
    rb = iv[22:19];
    rc = iv[18:15];
    ir = iv;
    run = 1'b1;
    mem_ready = 1'b0;
    tick($sformatf("%s_T0", nm), ov(C_SPC | C_EMAR | C_INC | C_EZ, prev_op, 16'h0, 16'h0));
    for (int k = 0; k <= wait_n; k++) begin
      mem_ready = (k == wait_n);
      tick($sformatf("%s_T1_%0d", nm, k),
           ov(C_SZL | C_RD | C_EMDR | ((k == 0) ? C_EPC : 17'h0), prev_op, 16'h0, 16'h0));
    end
    mem_ready = 1'b0;
    if (!run_after) run = 1'b0;
    tick($sformatf("%s_T2", nm), ov(C_SMDR | C_EIR, prev_op, 16'h0, 16'h0));
    if (op > 5'd12) begin
      tick($sformatf("%s_T3", nm), ov(17'h0, prev_op, 16'h0, 16'h0));
      prev_op = '0;
      for (int k = 0; k < 10; k++) tick($sformatf("%s_fault_%0d", nm, k), ov(C_FLT, 5'd0, 16'h0, 16'h0));
      w_clear = 1'b1;
      tick($sformatf("%s_fault_clr", nm), ov(C_FLT, 5'd0, 16'h0, 16'h0));
      w_clear = 1'b0;
      run = 1'b0;
      exp_count = 0;
      tick($sformatf("%s_after_clr", nm), ov(17'h0, 5'd0, 16'h0, 16'h0));
      return;
    end
    tick($sformatf("%s_T3", nm), ov(C_EY, prev_op, 16'd1 << rb, 16'h0));
    prev_op = op;
    ro4 = (op == 5'd4 || op == 5'd12) ? (16'd1 << rb) : (16'd1 << rc);
    if (abort_t4) begin
      w_clear = 1'b1;
      run = 1'b0;
    end
    tick($sformatf("%s_T4", nm), ov(C_ALU | C_EZ, op, ro4, 16'h0));
    if (abort_t4) begin
      w_clear = 1'b0;
      prev_op = '0;
      exp_count = 0;
      tick($sformatf("%s_reset_idle", nm), ov(17'h0, 5'd0, 16'h0, 16'h0));
      return;
    end
    cntq.push_back(exp_count);
    exp_count++;
    if (op == 5'd5 || op == 5'd6) begin
      latq.push_back(7 + wait_n);
      tick($sformatf("%s_T5", nm), ov(C_SZL | C_ELO, op, 16'h0, 16'h0));
      tick($sformatf("%s_T6", nm), ov(C_SZH | C_EHI | C_DONE, op, 16'h0, 16'h0));
    end else begin
      latq.push_back(6 + wait_n);
      tick($sformatf("%s_T5", nm), ov(C_SZL | C_DONE, op, 16'h0, 16'd1 << ra));
    end
    if (!run_after) begin
      prev_op = '0;
      tick($sformatf("%s_idle", nm), ov(17'h0, 5'd0, 16'h0, 16'h0));
    end
  endtask

  initial begin
    w_clear = 1'b1;
    run = 1'b0;
    mem_ready = 1'b0;
    ir = '0;
    @(posedge w_clock);
    #1;
    w_clear = 1'b0;
    tick("reset_idle", ov(17'h0, 5'd0, 16'h0, 16'h0));
    run = 1'b1;
    tick("idle_go", ov(17'h0, 5'd0, 16'h0, 16'h0));
    applyStimulus("add",  32'h00918000, 0, 1'b1, 1'b0);
    applyStimulus("shra", 32'h50918000, 3, 1'b1, 1'b0);
    applyStimulus("mul",  32'h28118000, 0, 1'b1, 1'b0);
    applyStimulus("not",  32'h20918000, 0, 1'b1, 1'b0);
    applyStimulus("div",  32'h30918000, 1, 1'b0, 1'b0);
    run = 1'b1;
    tick("idle_go2", ov(17'h0, 5'd0, 16'h0, 16'h0));
    applyStimulus("rol",  32'h38918000, 0, 1'b1, 1'b1);
    run = 1'b1;
    tick("idle_go3", ov(17'h0, 5'd0, 16'h0, 16'h0));
    applyStimulus("neg",  32'h60918000, 0, 1'b1, 1'b0);
    applyStimulus("ill",  32'hF8000000, 0, 1'b1, 1'b0);
    @(negedge w_clock);
    #1;
    checkOutput("drain", 64'(exps.size() + latq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
